display_bcd_varredura: RTL and testbench

//  Downstream consumer of the packed-BCD converter output (8 nibbles + neg flag).

---
 rtl/display_bcd_varredura.sv | 188 ++++++++++++++++++
 tb/tb_display_bcd_varredura.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_bcd_varredura.sv
// Time-multiplexed 8-digit common-anode seven-segment driver fed by packed BCD.
// New values are buffered and committed only on slot boundaries; outputs are registered.
module display_bcd_varredura #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_SCANS = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] segmentos,
    input  logic                    neg,
    input  logic                    atualiza,
    output logic [NUM_DIGITS-1:0]   anodo,
    output logic [6:0]              catodo,
    output logic                    estouro,
    output logic                    erro_bcd
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int DIG_W   = $clog2(NUM_DIGITS);
    localparam int SCAN_W  = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(BLINK_SCANS - 1);

    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        PH_ON,
        PH_OFF
    } phase_t;

    logic [PRESC_W-1:0]      presc;
    logic [DIG_W-1:0]        dig;
    logic [4*NUM_DIGITS-1:0] sombra;
    logic                    sombra_neg;
    logic                    pend;
    logic [4*NUM_DIGITS-1:0] ativo;
    logic                    ativo_neg;
    phase_t                  phase;
    phase_t                  phase_next;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [SCAN_W-1:0]       scan_cnt_next;

    logic                    slot_end;
    logic                    scan_wrap;
    logic                    commit;
    logic [4*NUM_DIGITS-1:0] commit_val;
    logic                    commit_neg;
    logic [DIG_W-1:0]        msd;
    logic [3:0]              nibble;
    logic [6:0]              code;
    logic [NUM_DIGITS-1:0]   anodo_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = SEG_E;
        endcase
    endfunction

    // Highest non-zero nibble; an all-zero value still reports digit 0.
    function automatic logic [DIG_W-1:0] find_msd(input logic [4*NUM_DIGITS-1:0] v);
        find_msd = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd0) find_msd = DIG_W'(i);
        end
    endfunction

    function automatic logic has_invalid(input logic [4*NUM_DIGITS-1:0] v);
        has_invalid = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) has_invalid = 1'b1;
        end
    endfunction

    assign slot_end   = (presc == PRESC_LAST);
    assign scan_wrap  = slot_end && (dig == DIG_LAST);
    // A strobe landing on the boundary edge goes straight to the display.
    assign commit     = slot_end && (pend || atualiza);
    assign commit_val = atualiza ? segmentos : sombra;
    assign commit_neg = atualiza ? neg : sombra_neg;

    // NOTE: every sequential register uses <= so all of them see pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            presc      <= '0;
            dig        <= '0;
            sombra     <= '0;
            sombra_neg <= 1'b0;
            pend       <= 1'b0;
            ativo      <= '0;
            ativo_neg  <= 1'b0;
            estouro    <= 1'b0;
            erro_bcd   <= 1'b0;
        end else begin
            if (slot_end) begin
                presc <= '0;
                dig   <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            if (atualiza) begin
                sombra     <= segmentos;
                sombra_neg <= neg;
                pend       <= 1'b1;
            end

            if (commit) begin
                ativo     <= commit_val;
                ativo_neg <= commit_neg;
                pend      <= 1'b0;
                estouro   <= commit_neg && (find_msd(commit_val) == DIG_LAST);
                erro_bcd  <= has_invalid(commit_val);
            end
        end
    end

    // NOTE: always_comb assigns defaults first so no path leaves a latch behind.
    always_comb begin
        phase_next    = phase;
        scan_cnt_next = scan_cnt;
        if (!estouro) begin
            phase_next    = PH_ON;
            scan_cnt_next = '0;
        end else if (scan_wrap) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt_next = '0;
                phase_next    = (phase == PH_ON) ? PH_OFF : PH_ON;
            end else begin
                scan_cnt_next = scan_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            phase    <= PH_ON;
            scan_cnt <= '0;
        end else begin
            phase    <= phase_next;
            scan_cnt <= scan_cnt_next;
        end
    end

    always_comb begin
        msd    = find_msd(ativo);
        nibble = ativo[4*int'(dig) +: 4];
        code   = SEG_BLANK;
        if (dig <= msd) begin
            code = seg_decode(nibble);
        end else if (ativo_neg && (int'(dig) == int'(msd) + 1)) begin
            code = SEG_MINUS;
        end
    end

    // First cycle of each slot is dark so the previous digit does not ghost.
    always_comb begin
        anodo_next = '1;
        if ((presc != '0) && !(estouro && (phase == PH_OFF))) begin
            anodo_next[dig] = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            anodo  <= '1;
            catodo <= SEG_BLANK;
        end else begin
            anodo  <= anodo_next;
            catodo <= code;
        end
    end

endmodule

// File: tb/tb_display_bcd_varredura.sv
// Directed bench for display_bcd_varredura with SCAN_DIV=4, BLINK_SCANS=2, NUM_DIGITS=8.
// Tracks the edge count since reset to know which slot the display is in.
module tb_display_bcd_varredura;

    localparam int SD = 4;
    localparam int ND = 8;

    logic          clock;
    logic          reset;
    logic [31:0]   segmentos;
    logic          neg;
    logic          atualiza;
    logic [7:0]    anodo;
    logic [6:0]    catodo;
    logic          estouro;
    logic          erro_bcd;

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;

    display_bcd_varredura #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_SCANS(2)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .segmentos(segmentos),
        .neg      (neg),
        .atualiza (atualiza),
        .anodo    (anodo),
        .catodo   (catodo),
        .estouro  (estouro),
        .erro_bcd (erro_bcd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]      val;
        logic             sgn;
        logic [7:0][6:0]  code;   // listed d7 .. d0
        logic             est;
        logic             err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        k++;
    endtask

    task automatic strobe(input logic [31:0] v, input logic s);
        segmentos = v;
        neg       = s;
        atualiza  = 1'b1;
        tick();
        atualiza  = 1'b0;
    endtask

    // Stop right after the edge whose pre-edge state was (dig d, presc 2).
    task automatic at_slot(input int d);
        int n;
        n = 1;
        tick();
        while (!(((k - 1) % SD == 2) && (((k - 1) / SD) % ND == d)) && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL at_slot_timeout: got %0d cycles, expected < 64", n);
        end
    endtask

    // Stop when the DUT state is (dig d, presc p).
    task automatic wait_state(input int d, input int p);
        int n;
        n = 1;
        tick();
        while (!((k % SD == p) && ((k / SD) % ND == d)) && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_state_timeout: got %0d cycles, expected < 64", n);
        end
    endtask

    function automatic logic [7:0] lit(input int d);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << d);
    endfunction

    initial begin
        logic [7:0][6:0] ovf_code;
        logic [7:0]      exp_an;
        int              g;

        ovf_code = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

        vecs[0] = '{val: 32'h00001234, sgn: 1'b0, est: 1'b0, err: 1'b0,
                    code: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{val: 32'h00000057, sgn: 1'b1, est: 1'b0, err: 1'b0,
                    code: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h12, 7'h78}};
        vecs[2] = '{val: 32'h00000000, sgn: 1'b0, est: 1'b0, err: 1'b0,
                    code: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{val: 32'h00000000, sgn: 1'b1, est: 1'b0, err: 1'b0,
                    code: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h40}};
        vecs[4] = '{val: 32'h0000000A, sgn: 1'b0, est: 1'b0, err: 1'b1,
                    code: {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h06}};
        vecs[5] = '{val: 32'h000F0E09, sgn: 1'b0, est: 1'b0, err: 1'b1,
                    code: {7'h7F, 7'h7F, 7'h7F, 7'h06, 7'h40, 7'h06, 7'h40, 7'h10}};
        vecs[6] = '{val: 32'h09876543, sgn: 1'b1, est: 1'b0, err: 1'b0,
                    code: {7'h3F, 7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30}};
        vecs[7] = '{val: 32'h10000000, sgn: 1'b0, est: 1'b0, err: 1'b0,
                    code: {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

        segmentos = '0;
        neg       = 1'b0;
        atualiza  = 1'b0;
        reset     = 1'b0;

        // Power-on reset held for three edges
        repeat (3) tick();
        reset = 1'b1;
        k = 0;
        check("rst_anodo", anodo, 8'hFF);
        check("rst_catodo", catodo, 7'h7F);
        check("rst_estouro", estouro, 1'b0);
        check("rst_erro", erro_bcd, 1'b0);
        tick();
        check("rst_first_guard", anodo, 8'hFF);
        tick();
        check("rst_first_digit_an", anodo, 8'hFE);
        check("rst_first_digit_cat", catodo, 7'h40);

        for (int i = 0; i < 8; i++) begin
            strobe(vecs[i].val, vecs[i].sgn);
            repeat (5) tick();
            check($sformatf("v%0d_estouro", i), estouro, vecs[i].est);
            check($sformatf("v%0d_erro", i), erro_bcd, vecs[i].err);
            for (int d = 0; d < ND; d++) begin
                at_slot(d);
                check($sformatf("v%0d_d%0d_an", i, d), anodo, lit(d));
                check($sformatf("v%0d_d%0d_cat", i, d), catodo, vecs[i].code[d]);
            end
        end

        // Exactly one dark guard cycle per slot
        wait_state(2, 0);
        g = 0;
        for (int c = 0; c < SD; c++) begin
            tick();
            if (anodo == 8'hFF) g++;
        end
        check("guard_cycles_per_slot", g, 1);

        // Two strobes before one commit: the second one is shown
        wait_state(3, 0);
        strobe(32'h00000011, 1'b0);
        strobe(32'h00000022, 1'b0);
        at_slot(0);
        check("last_wins_d0", catodo, 7'h24);
        at_slot(1);
        check("last_wins_d1", catodo, 7'h24);

        // Mid-slot strobe holds until the slot ends
        wait_state(0, 1);
        strobe(32'h0000000A, 1'b0);
        check("hold_p1_cat", catodo, 7'h24);
        check("hold_p1_erro", erro_bcd, 1'b0);
        tick();
        check("hold_p2_cat", catodo, 7'h24);
        tick();
        check("hold_p3_cat", catodo, 7'h24);
        check("commit_erro", erro_bcd, 1'b1);
        at_slot(0);
        check("commit_d0_E", catodo, 7'h06);

        // Overflow: strobe on the scan-wrap edge bypasses straight to the display
        at_slot(7);
        check("pre_ovf_estouro", estouro, 1'b0);
        strobe(32'h12345678, 1'b1);
        check("ovf_estouro", estouro, 1'b1);
        check("ovf_erro", erro_bcd, 1'b0);
        for (int s = 0; s < 7; s++) begin
            for (int d = 0; d < ND; d++) begin
                at_slot(d);
                exp_an = ((s % 4) >= 2) ? 8'hFF : lit(d);
                check($sformatf("ovf_s%0d_d%0d_an", s, d), anodo, exp_an);
                check($sformatf("ovf_s%0d_d%0d_cat", s, d), catodo, ovf_code[d]);
                if (s == 6 && d == 3) begin
                    strobe(32'h00001234, 1'b0);
                    repeat (4) tick();
                    check("ovf_fall_estouro", estouro, 1'b0);
                    at_slot(5);
                    check("ovf_fall_lit", anodo, lit(5));
                    break;
                end
            end
        end

        // Re-enter overflow: blink phase must have restarted ON
        at_slot(7);
        strobe(32'h12345678, 1'b1);
        for (int s = 0; s < 3; s++) begin
            for (int d = 0; d < ND; d += 3) begin
                at_slot(d);
                exp_an = (s >= 2) ? 8'hFF : lit(d);
                check($sformatf("ovf2_s%0d_d%0d_an", s, d), anodo, exp_an);
            end
        end

        // Reset mid-scan at digit 5 while flags are set
        wait_state(5, 2);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        k = 0;
        check("mid_rst_anodo", anodo, 8'hFF);
        check("mid_rst_catodo", catodo, 7'h7F);
        check("mid_rst_estouro", estouro, 1'b0);
        check("mid_rst_erro", erro_bcd, 1'b0);
        tick();
        check("mid_rst_guard", anodo, 8'hFF);
        tick();
        check("mid_rst_restart_an", anodo, 8'hFE);
        check("mid_rst_restart_cat", catodo, 7'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
